// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: circular buffer of {pc, inst} with valid/ready on the ID side and flush.
// Optional head predecode of control-flow opcodes under `IF_ID_PREDECODE_EN`.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int AW     = 32,
    parameter int IW     = 32,
    parameter int PC_ADJ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_flag,
    input  logic [AW-1:0]              if_pc,
    input  logic [IW-1:0]              if_inst,
    output logic                       if_ready,
    output logic                       id_flag,
    output logic [AW-1:0]              id_pc,
    output logic [IW-1:0]              id_inst,
    input  logic                       id_ready,
`ifdef IF_ID_PREDECODE_EN
    output logic                       id_is_ctrl,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem_pc   [DEPTH];
    logic [IW-1:0] mem_inst [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Full is judged on occupancy alone: a same-cycle pop does not free a slot.
    assign if_ready = (cnt != CW'(DEPTH));
    assign id_flag  = (cnt != '0);
    assign push     = if_flag & if_ready & ~flush;
    assign pop      = id_flag & id_ready & ~flush;
    assign count    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never reset; id_flag gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= if_pc - AW'(PC_ADJ);
            mem_inst[wr_ptr] <= if_inst;
        end
    end

    assign id_pc   = id_flag ? mem_pc[rd_ptr]   : '0;
    assign id_inst = id_flag ? mem_inst[rd_ptr] : '0;

`ifdef IF_ID_PREDECODE_EN
    logic [6:0] opcode;
    assign opcode     = id_inst[6:0];
    assign id_is_ctrl = id_flag & ((opcode == 7'b1101111) |
                                   (opcode == 7'b1100111) |
                                   (opcode == 7'b1100011));
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          if_flag = 1'b0;
    logic [31:0]   if_pc = '0;
    logic [31:0]   if_inst = '0;
    logic          if_ready;
    logic          id_flag;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic          id_ready = 1'b0;
    logic [CW-1:0] count;
`ifdef IF_ID_PREDECODE_EN
    logic          id_is_ctrl;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;
    entry_t model_q[$];

    if_id_queue #(.DEPTH(DEPTH), .AW(32), .IW(32), .PC_ADJ(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_flag(if_flag), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_flag(id_flag), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
`ifdef IF_ID_PREDECODE_EN
        .id_is_ctrl(id_is_ctrl),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of adjusted entries updated on each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            automatic bit do_push = if_flag && (model_q.size() < DEPTH) && !flush;
            automatic bit do_pop  = (model_q.size() != 0) && id_ready && !flush;
            if (flush) model_q.delete();
            else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back({if_pc - 32'd4, if_inst});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic bit          exp_vld  = model_q.size() != 0;
            automatic logic [31:0] exp_pc   = exp_vld ? model_q[0].pc   : 32'd0;
            automatic logic [31:0] exp_inst = exp_vld ? model_q[0].inst : 32'd0;
            chk("m_id_flag",  64'(id_flag),  64'(exp_vld));
            chk("m_id_pc",    64'(id_pc),    64'(exp_pc));
            chk("m_id_inst",  64'(id_inst),  64'(exp_inst));
            chk("m_count",    64'(count),    64'(model_q.size()));
            chk("m_if_ready", 64'(if_ready), 64'(model_q.size() < DEPTH));
`ifdef IF_ID_PREDECODE_EN
            chk("m_is_ctrl", 64'(id_is_ctrl), 64'(exp_vld && (exp_inst[6:0] == 7'h6F ||
                exp_inst[6:0] == 7'h67 || exp_inst[6:0] == 7'h63)));
`endif
        end
    end

    // Drive one cycle of inputs (called at a negedge) and return at the next negedge.
    task automatic cyc(input bit f, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl);
        if_flag  = f;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        @(negedge clk);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_id_flag",  64'(id_flag),  64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_id_pc",    64'(id_pc),    64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Single push: PC correction and one-cycle visibility.
        cyc(1, 32'h104, 32'h00500093, 0, 0);
        chk("one_id_flag", 64'(id_flag), 64'd1);
        chk("one_id_pc",   64'(id_pc),   64'h100);
        chk("one_id_inst", 64'(id_inst), 64'h00500093);
        chk("one_count",   64'(count),   64'd1);
        cyc(0, 0, 0, 1, 0);

        // Fill, overfill, drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 0, 0);
        chk("full_count",    64'(count),    64'd4);
        chk("full_if_ready", 64'(if_ready), 64'd0);
        cyc(1, 32'h999, 32'hDEAD, 0, 0);
        chk("over_count", 64'(count), 64'd4);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_pc",   64'(id_pc),   64'(32'h1FC + 32'(4 * i)));
            chk("drain_inst", 64'(id_inst), 64'(32'hA000 + 32'(i)));
            cyc(0, 0, 0, 1, 0);
        end
        chk("empty_flag", 64'(id_flag), 64'd0);
        chk("empty_pc",   64'(id_pc),   64'd0);
        chk("empty_inst", 64'(id_inst), 64'd0);

        // Streaming push+pop, occupancy steady at one across pointer wrap.
        cyc(1, 32'h4, 32'h1, 1, 0);
        for (int i = 2; i <= 11; i++) begin
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc",    64'(id_pc), 64'(32'(4 * (i - 2))));
            cyc(1, 32'(4 * i), 32'(i), 1, 0);
        end
        cyc(0, 0, 0, 1, 0);

        // Flush with three entries while pushing and popping.
        for (int i = 0; i < 3; i++) cyc(1, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 0, 0);
        cyc(1, 32'h400, 32'hBEEF, 1, 1);
        chk("flush_count",    64'(count),    64'd0);
        chk("flush_id_flag",  64'(id_flag),  64'd0);
        chk("flush_if_ready", 64'(if_ready), 64'd1);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h504, 32'hC0, 0, 0);
        chk("post_flush_pc", 64'(id_pc), 64'h500);
        cyc(0, 0, 0, 1, 0);

        // Asynchronous reset between edges with two entries queued.
        cyc(1, 32'h604, 32'hD0, 0, 0);
        cyc(1, 32'h608, 32'hD1, 0, 0);
        if_flag = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count",    64'(count),    64'd0);
        chk("arst_id_flag",  64'(id_flag),  64'd0);
        chk("arst_if_ready", 64'(if_ready), 64'd1);
        chk("arst_id_inst",  64'(id_inst),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 32'h704, 32'hE0, 0, 0);
        chk("after_rst_count", 64'(count), 64'd1);
        chk("after_rst_pc",    64'(id_pc), 64'h700);
        cyc(0, 0, 0, 1, 0);

`ifdef IF_ID_PREDECODE_EN
        chk("pd_empty", 64'(id_is_ctrl), 64'd0);
        cyc(1, 32'h804, 32'h0000006F, 0, 0);
        chk("pd_jal", 64'(id_is_ctrl), 64'd1);
        cyc(1, 32'h808, 32'h00000013, 1, 0);
        chk("pd_addi", 64'(id_is_ctrl), 64'd0);
        cyc(0, 0, 0, 1, 0);
`endif

        // Random traffic; the model compare checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch/decode decoupling queue between the IF and ID stages. Holds up to DEPTH fetched instructions (PC plus instruction word), so a one-cycle ID stall no longer discards fetched work. It presents the oldest entry to ID with a valid/ready handshake and applies the fixed PC correction on write. It also supports a single-cycle flush for branch/jump redirection.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥2.
- AW, 32: PC width.
- IW, 32: instruction width.
- PC_ADJ, 4: constant subtracted from if_pc on write (IF reports PC+4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries and any same-cycle push.
- if_flag  in  1  IF offers a valid instruction.
- if_pc  in  AW  IF PC (post-increment).
- if_inst  in  IW  fetched instruction.
- if_ready  out  1  queue can accept: count < DEPTH.
- id_flag  out  1  head entry valid: count ≠ 0.
- id_pc  out  AW  head PC (already adjusted).
- id_inst  out  IW  head instruction.
- id_ready  in  1  ID consumes the head this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- id_is_ctrl  out  1  head is branch/jump; present only with IF_ID_PREDECODE_EN.

## Operation
- Storage: circular buffer of DEPTH entries {pc, inst} with wr_ptr, rd_ptr ($clog2(DEPTH) bits) and count.
- Push = if_flag & if_ready & ~flush. Stores {if_pc − PC_ADJ (mod 2^AW), if_inst} at wr_ptr, then increments wr_ptr.
- Pop = id_flag & id_ready & ~flush. Increments rd_ptr.
- count next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- Pointers wrap naturally from DEPTH−1 to 0.
- Outputs are driven from registered state only. No combinational path from if_* or id_ready to id_*.
- When id_flag=0, id_pc and id_inst are forced to 0.
- Full: if_ready=0, and no push occurs even if ID pops that cycle. There is no same-cycle credit, so if_ready depends on count alone.
- Empty: id_ready is ignored; the pointers do not move.
- Flush has priority over everything:
  - next edge: wr_ptr = rd_ptr = count = 0;
  - push and pop in that cycle are both suppressed.
- Reset (async, any time, including mid-stream): pointers and count = 0. Outputs immediately become id_flag=0, id_pc=0, id_inst=0, if_ready=1, count=0 (id_is_ctrl=0). Storage contents need no reset.

## Timing
- Write-to-read latency is 1 cycle: a push at edge N is visible on id_* after edge N.
- Throughput is one push and one pop per cycle in steady state.
- if_ready, id_flag and count change only on clk edges or asynchronously on rst.
- After flush is asserted at edge N, id_flag=0 and if_ready=1 from edge N onward. A push is accepted again in cycle N+1.

## Configuration
- IF_ID_PREDECODE_EN defined:
  - adds output id_is_ctrl = id_flag & (opcode id_inst[6:0] ∈ {7'b1101111, 7'b1100111, 7'b1100011});
  - it is combinational from the head entry and adds no latency.
- Undefined: port id_is_ctrl and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then single push of if_pc=0x104, if_inst=0x00500093 with id_ready=0:
  - next cycle id_flag=1, id_pc=0x100, id_inst=0x00500093, count=1.
- Fill with DEPTH=4 pushes and id_ready=0:
  - count=4, if_ready=0;
  - a fifth if_flag is ignored;
  - drain with id_ready=1 returns the four entries in order, then id_flag=0, id_pc=0, id_inst=0.
- Continuous push+pop for 10 cycles with PCs 0x4,0x8,…:
  - id_pc follows 0x0,0x4,… one cycle behind;
  - count holds 1;
  - pointers wrap with no lost or duplicated entry.
- Flush with count=3 while if_flag=1 and id_ready=1:
  - next cycle count=0, id_flag=0, if_ready=1;
  - neither the pushed nor the popped entry appears later.
- rst pulsed between clock edges with count=2:
  - outputs reach reset values without waiting for clk;
  - after release, the first push appears alone at the head.
- With IF_ID_PREDECODE_EN:
  - head inst 0x0000006F (jal) gives id_is_ctrl=1;
  - 0x00000013 (addi) gives 0;
  - empty queue gives 0.
